// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller:
// size defaults, FSM state encoding and requester select.
package rf_ctrl_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The last-served pointer only advances when the
// caller accepts the proposed grant.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic elig_a_i,
  input  logic elig_b_i,
  input  logic accept_i,
  output sel_e sel_o,
  output logic valid_o
);

  sel_e last_q, last_d;

  always_comb begin
    valid_o = elig_a_i | elig_b_i;
    if (elig_a_i && elig_b_i) begin
      sel_o = (last_q == SEL_A) ? SEL_B : SEL_A;
    end else if (elig_a_i) begin
      sel_o = SEL_A;
    end else begin
      sel_o = SEL_B;
    end
    last_d = (accept_i && valid_o) ? sel_o : last_q;
  end

  // Reset to "B served last" so the first contended grant goes to A.
  always_ff @(posedge clk) begin
    if (srst) begin
      last_q <= SEL_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Write-port controller: round-robin between two requesters plus a clear sweep.
// Optional feature macro: RF_R0_PROTECT_EN (register 0 hardwired to zero).
module rf_write_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                A_REQ,
  input  logic [ADDR_W-1:0]   A_ADDR,
  input  logic [DATA_W-1:0]   A_DATA,
  output logic                A_GNT,
  input  logic                B_REQ,
  input  logic [ADDR_W-1:0]   B_ADDR,
  input  logic [DATA_W-1:0]   B_DATA,
  output logic                B_GNT,
  input  logic                CLR_START,
  output logic                BUSY,
  output logic                CLR_DONE,
  output logic [NUM_REGS-1:0] RF_L,
  output logic [DATA_W-1:0]   RF_D
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                a_gnt_q, a_gnt_d;
  logic                b_gnt_q, b_gnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_REGS-1:0] rf_l_q, rf_l_d;
  logic [DATA_W-1:0]   rf_d_q, rf_d_d;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_idx;
  logic                accept;
  logic                arb_valid;
  sel_e                arb_sel;

  // A requester whose grant is showing this cycle is not eligible again yet.
  rr_arb2 u_arb (
    .clk      (CLK),
    .srst     (RST),
    .elig_a_i (A_REQ & ~a_gnt_q),
    .elig_b_i (B_REQ & ~b_gnt_q),
    .accept_i (accept),
    .sel_o    (arb_sel),
    .valid_o  (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rf_d_d  = '0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CLR_START) begin
          // The first sweep write (index 0) goes out in the cycle after the start.
          wr_en  = 1'b1;
          busy_d = 1'b1;
          if (LAST_IDX == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_CLEAR;
            cnt_d   = ADDR_W'(1);
          end
        end else if (arb_valid) begin
          accept = 1'b1;
          wr_en  = 1'b1;
          if (arb_sel == SEL_A) begin
            a_gnt_d = 1'b1;
            wr_idx  = A_ADDR;
            rf_d_d  = A_DATA;
          end else begin
            b_gnt_d = 1'b1;
            wr_idx  = B_ADDR;
            rf_d_d  = B_DATA;
          end
        end
      end
      ST_CLEAR: begin
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        busy_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Addresses at or beyond NUM_REGS match no decoder bit, so the write drops.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
`ifdef RF_R0_PROTECT_EN
    if (gi == 0) begin : g_r0
      assign rf_l_d[gi] = 1'b0;
    end else begin : g_wr
      assign rf_l_d[gi] = wr_en && (wr_idx == ADDR_W'(gi));
    end
`else
    assign rf_l_d[gi] = wr_en && (wr_idx == ADDR_W'(gi));
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rf_l_q  <= '0;
      rf_d_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rf_l_q  <= rf_l_d;
      rf_d_q  <= rf_d_d;
    end
  end

  assign A_GNT    = a_gnt_q;
  assign B_GNT    = b_gnt_q;
  assign BUSY     = busy_q;
  assign CLR_DONE = done_q;
  assign RF_L     = rf_l_q;
  assign RF_D     = rf_d_q;

endmodule
